// File: rtl/dpram_bm.sv
// rtl/dpram_bm.sv - single-clock byte-masked simple dual-port RAM
// Optional zero sweep after reset, 1- or 2-cycle pipelined read, selectable collision forwarding.
module dpram_bm #(
  parameter int VECTOR_LENGTH  = 512,
  parameter int WORD_WIDTH     = 32,
  parameter int READ_LATENCY   = 1,
  parameter int BYPASS         = 1,
  parameter int CLEAR_ON_RESET = 1,
  localparam int ADDR_WIDTH    = $clog2(VECTOR_LENGTH),
  localparam int NB            = WORD_WIDTH / 8
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  ready_o,
  input  logic                  re_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [WORD_WIDTH-1:0] rdata_o,
  output logic                  rvalid_o,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [WORD_WIDTH-1:0] wdata_i,
  input  logic [NB-1:0]         wbytemask_i
);

  typedef enum logic {S_CLEAR, S_RUN} state_t;

  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(VECTOR_LENGTH - 1);
  localparam logic [ADDR_WIDTH:0]   DEPTH     = (ADDR_WIDTH + 1)'(VECTOR_LENGTH);

  logic [WORD_WIDTH-1:0] mem [VECTOR_LENGTH];

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_cnt_q;
  logic                  ready_q;
  logic                  run;
  logic                  wr_en, rd_en;
  logic                  rd_in_range, wr_in_range;
  logic [WORD_WIDTH-1:0] rd_word;
  logic                  s1_valid, s2_valid;
  logic [WORD_WIDTH-1:0] s1_data, s2_data;
  logic                  out_valid;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  rvalid_q;
  logic [WORD_WIDTH-1:0] rdata_q;

  assign run         = (state_q == S_RUN);
  assign rd_in_range = ({1'b0, raddr_i} < DEPTH);
  assign wr_in_range = ({1'b0, waddr_i} < DEPTH);
  assign wr_en       = run & we_i & wr_in_range;
  assign rd_en       = run & re_i;

  always_comb begin
    state_d = state_q;
    if (state_q == S_CLEAR && clr_cnt_q == LAST_ADDR) begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= RESET_STATE;
      clr_cnt_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= run;
      if (state_q == S_CLEAR) begin
        clr_cnt_q <= (clr_cnt_q == LAST_ADDR) ? '0 : clr_cnt_q + 1'b1;
      end
    end
  end

  // Array has no reset; the sweep writes zeros while user ports are blocked.
  always_ff @(posedge clk_i) begin
    if (state_q == S_CLEAR) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < NB; k++) begin
        if (wbytemask_i[k]) begin
          mem[waddr_i][8*k +: 8] <= wdata_i[8*k +: 8];
        end
      end
    end
  end

  // Array is sampled at the issue edge, so later writes never reach this read.
  always_comb begin
    rd_word = '0;
    if (rd_in_range) begin
      rd_word = mem[raddr_i];
    end
    if (BYPASS != 0 && wr_en && raddr_i == waddr_i) begin
      for (int k = 0; k < NB; k++) begin
        if (wbytemask_i[k]) begin
          rd_word[8*k +: 8] = wdata_i[8*k +: 8];
        end
      end
    end
  end

  assign out_valid = (READ_LATENCY == 2) ? s2_valid : s1_valid;
  assign out_data  = (READ_LATENCY == 2) ? s2_data  : s1_data;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s2_valid <= 1'b0;
      s2_data  <= '0;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      s1_valid <= rd_en;
      if (rd_en) s1_data <= rd_word;
      s2_valid <= s1_valid;
      if (s1_valid) s2_data <= s1_data;
      rvalid_q <= out_valid;
      if (out_valid) rdata_q <= out_data;
    end
  end

  assign ready_o  = ready_q;
  assign rvalid_o = rvalid_q;
  assign rdata_o  = rdata_q;

endmodule

// File: tb/tb_dpram_bm.sv
// tb/tb_dpram_bm.sv - directed bench for dpram_bm
// Two instances share stimulus: a = 16 words, latency 1, forwarding; b = 12 words, latency 2, no forwarding.
module tb_dpram_bm;

  logic        clk;
  logic        rst_n;
  logic        re, we;
  logic [3:0]  raddr, waddr;
  logic [31:0] wdata;
  logic [3:0]  mask;

  logic        ready_a, rvalid_a, ready_b, rvalid_b;
  logic [31:0] rdata_a, rdata_b;

  int checks   = 0;
  int failures = 0;

  dpram_bm #(
    .VECTOR_LENGTH(16), .WORD_WIDTH(32), .READ_LATENCY(1), .BYPASS(1), .CLEAR_ON_RESET(1)
  ) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .ready_o(ready_a),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_a), .rvalid_o(rvalid_a),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbytemask_i(mask)
  );

  dpram_bm #(
    .VECTOR_LENGTH(12), .WORD_WIDTH(32), .READ_LATENCY(2), .BYPASS(0), .CLEAR_ON_RESET(1)
  ) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .ready_o(ready_b),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata_b), .rvalid_o(rvalid_b),
    .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wbytemask_i(mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Inputs for the issue edge are already driven; follows the read through both latencies.
  task automatic finish_read(input string tag, input logic [31:0] ea, input logic [31:0] eb);
    tick();
    re = 1'b0;
    we = 1'b0;
    chk({tag, "_a_v0"}, 32'(rvalid_a), 32'd0);
    chk({tag, "_b_v0"}, 32'(rvalid_b), 32'd0);
    tick();
    chk({tag, "_a_v1"}, 32'(rvalid_a), 32'd1);
    chk({tag, "_a_d"},  rdata_a, ea);
    chk({tag, "_b_v1"}, 32'(rvalid_b), 32'd0);
    tick();
    chk({tag, "_a_v2"}, 32'(rvalid_a), 32'd0);
    chk({tag, "_b_v2"}, 32'(rvalid_b), 32'd1);
    chk({tag, "_b_d"},  rdata_b, eb);
  endtask

  task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] ea, input logic [31:0] eb);
    re = 1'b1;
    raddr = a;
    finish_read(tag, ea, eb);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] m);
    we = 1'b1;
    waddr = a;
    wdata = d;
    mask = m;
    tick();
    we = 1'b0;
  endtask

  logic [31:0] pipe_data [3];

  initial begin
    rst_n = 1'b0;
    re = 1'b0; we = 1'b0;
    raddr = '0; waddr = '0; wdata = '0; mask = '0;
    tick(); tick();
    chk("rst_ready_a", 32'(ready_a), 32'd0);
    chk("rst_ready_b", 32'(ready_b), 32'd0);
    chk("rst_rvalid_a", 32'(rvalid_a), 32'd0);
    chk("rst_rvalid_b", 32'(rvalid_b), 32'd0);
    chk("rst_rdata_a", rdata_a, 32'd0);
    chk("rst_rdata_b", rdata_b, 32'd0);

    // Clear sweep with writes hammering address 0; they must be ignored.
    rst_n = 1'b1;
    we = 1'b1; waddr = 4'd0; wdata = 32'hFFFF_FFFF; mask = 4'hF;
    for (int k = 1; k <= 18; k++) begin
      tick();
      chk($sformatf("sweep_ready_a_e%0d", k), 32'(ready_a), 32'(k >= 17));
      chk($sformatf("sweep_ready_b_e%0d", k), 32'(ready_b), 32'(k >= 13));
      chk($sformatf("sweep_rvalid_a_e%0d", k), 32'(rvalid_a), 32'd0);
      if (k == 12) we = 1'b0;
    end
    for (int i = 0; i < 16; i++) rd($sformatf("zero%0d", i), 4'(i), 32'd0, 32'd0);

    // Byte mask merge.
    wr(4'd5, 32'hAABB_CCDD, 4'b1111);
    wr(4'd5, 32'h1122_3344, 4'b0101);
    rd("bmask", 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);
    wr(4'd5, 32'h0000_0000, 4'b0000);
    rd("mask0", 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);

    // Same-cycle collision on address 2 (holds zero).
    re = 1'b1; raddr = 4'd2;
    we = 1'b1; waddr = 4'd2; wdata = 32'hFFFF_FFFF; mask = 4'b0011;
    finish_read("coll", 32'h0000_FFFF, 32'h0000_0000);
    rd("coll_after", 4'd2, 32'h0000_FFFF, 32'h0000_FFFF);

    // Back-to-back reads of 3,4,5.
    wr(4'd3, 32'h3333_3333, 4'hF);
    wr(4'd4, 32'h4444_4444, 4'hF);
    pipe_data[0] = 32'h3333_3333;
    pipe_data[1] = 32'h4444_4444;
    pipe_data[2] = 32'hAA22_CC44;
    for (int t = 0; t < 6; t++) begin
      re = (t < 3);
      raddr = 4'(3 + t);
      tick();
      chk($sformatf("pipe_a_v_t%0d", t), 32'(rvalid_a), 32'(t >= 1 && t <= 3));
      chk($sformatf("pipe_b_v_t%0d", t), 32'(rvalid_b), 32'(t >= 2 && t <= 4));
      if (t >= 1 && t <= 3) chk($sformatf("pipe_a_d_t%0d", t), rdata_a, pipe_data[t-1]);
      if (t >= 2 && t <= 4) chk($sformatf("pipe_b_d_t%0d", t), rdata_b, pipe_data[t-2]);
    end
    chk("hold_a", rdata_a, 32'hAA22_CC44);
    chk("hold_b", rdata_b, 32'hAA22_CC44);

    // Write one cycle after issue must not leak into the latency-2 read.
    re = 1'b1; raddr = 4'd3;
    tick();
    re = 1'b0;
    we = 1'b1; waddr = 4'd3; wdata = 32'hCAFE_F00D; mask = 4'hF;
    tick();
    we = 1'b0;
    chk("late_wr_a", rdata_a, 32'h3333_3333);
    tick();
    chk("late_wr_b_v", 32'(rvalid_b), 32'd1);
    chk("late_wr_b", rdata_b, 32'h3333_3333);
    tick();
    rd("late_wr_after", 4'd3, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // Address 13 is in range for a, out of range for b.
    wr(4'd13, 32'hDEAD_BEEF, 4'hF);
    rd("oor13", 4'd13, 32'hDEAD_BEEF, 32'd0);
    rd("oor_keep5", 4'd5, 32'hAA22_CC44, 32'hAA22_CC44);
    rd("oor_keep1", 4'd1, 32'd0, 32'd0);
    rd("oor_keep11", 4'd11, 32'd0, 32'd0);

    // Reset one cycle after a read issue.
    re = 1'b1; raddr = 4'd5;
    tick();
    re = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_ready_a", 32'(ready_a), 32'd0);
    chk("mid_ready_b", 32'(ready_b), 32'd0);
    chk("mid_rdata_a", rdata_a, 32'd0);
    chk("mid_rdata_b", rdata_b, 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk($sformatf("mid_rvalid_a_%0d", k), 32'(rvalid_a), 32'd0);
      chk($sformatf("mid_rvalid_b_%0d", k), 32'(rvalid_b), 32'd0);
    end
    // Partial sweep, then reset again: the next sweep must restart from 0.
    rst_n = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 17; k++) begin
      tick();
      chk($sformatf("resweep_ready_a_e%0d", k), 32'(ready_a), 32'(k >= 17));
      chk($sformatf("resweep_ready_b_e%0d", k), 32'(ready_b), 32'(k >= 13));
      chk($sformatf("resweep_rvalid_b_e%0d", k), 32'(rvalid_b), 32'd0);
    end
    rd("resweep5", 4'd5, 32'd0, 32'd0);
    rd("resweep13", 4'd13, 32'd0, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
